cmd_serializer: RTL and testbench

Serializes the 16-bit command words in the 160 MHz domain into a continuous 1-bit command stream at one bit per `clk160` cycle. It sits directly downstream of the 40→160 command FIFO: it issues single-cycle reads, holds one prefetched word, and emits MSB-first 16-bit frames. When no command is available it emits an idle word, and it inserts a sync word at a fixed frame interval.

---
 rtl/cmd_serializer.sv | 185 ++++++++++++++++++
 tb/tb_cmd_serializer.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_serializer.sv
// cmd_serializer: turns 16-bit command words from the 40->160 command FIFO
// into a continuous MSB-first bit stream at one bit per clk160 cycle.
// Frames are either a sync word (at a fixed frame interval and on every
// start of streaming), a prefetched command word, or an idle filler word.
// One command word is prefetched per frame into a single-entry hold register.
module cmd_serializer #(
    parameter int unsigned SYNC_INTERVAL = 32,       // frames per sync period, 2..255
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter logic [15:0] IDLE_WORD     = 16'h6969
) (
    input  logic        clk160,
    input  logic        rst,           // synchronous, active-low
    input  logic        en,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        rd_cmd,
    output logic        ser_out,
    output logic        frame_start,
    output logic [1:0]  frame_type,
    output logic [15:0] cmd_sent_cnt,
    output logic        ovf_err
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_SYNC = 2'b01,
        FT_IDLE = 2'b10,
        FT_CMD  = 2'b11
    } frame_type_t;

    // Sync counter value at which the next frame to be loaded is a sync frame.
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_INTERVAL - 1);

    // The bit-12 read strobe is registered, so it is decided one cycle early.
    localparam logic [3:0] PREFETCH_DECIDE = 4'd11;
    localparam logic [3:0] LAST_BIT        = 4'd15;

    state_t      state;
    logic [3:0]  bit_cnt;       // position of the bit currently on ser_out
    logic [15:0] shift_reg;     // frame being shifted out, MSB on ser_out
    logic [7:0]  sync_cnt;      // frames loaded since the last sync frame
    logic        hold_full;
    logic [15:0] hold_data;

    logic        sync_due;
    logic        frame_end;
    logic        load_frame;
    logic        take_hold;
    logic        hold_full_nxt;
    logic        capture;
    logic        ovf_set;
    logic        prefetch;
    logic [15:0] next_word;
    frame_type_t next_type;

    // The stream bit is taken straight from the shift register flop.
    assign ser_out = shift_reg[15];

    // A frame entered from IDLE is always a sync frame; otherwise the
    // counter decides.
    assign sync_due   = (state == ST_IDLE) || (sync_cnt == SYNC_LAST);
    assign frame_end  = (state == ST_RUN) && (bit_cnt == LAST_BIT);
    // A new frame is loaded when streaming starts or a frame ends while enabled.
    assign load_frame = en && ((state == ST_IDLE) || frame_end);
    // The held word leaves the hold register only when it is actually sent.
    assign take_hold  = load_frame && !sync_due && hold_full;

    // Hold register next state: a frame load empties it first, so a word
    // arriving in the same cycle is captured instead of overflowing.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // and blocking '=' is used so later lines see the updated value;
        // together this keeps the block free of inferred latches.
        hold_full_nxt = hold_full;
        capture       = 1'b0;
        ovf_set       = 1'b0;
        if (take_hold) begin
            hold_full_nxt = 1'b0;
        end
        if (cmd_valid) begin
            if (hold_full_nxt) begin
                ovf_set = 1'b1;
            end else begin
                capture       = 1'b1;
                hold_full_nxt = 1'b1;
            end
        end
    end

    // Request a word so that it pulses during bit 12: only when the hold
    // register will be empty, no read is in flight, and the next frame is
    // not a sync frame (a word fetched then would just sit in the hold).
    assign prefetch = (state == ST_RUN)
                   && (bit_cnt == PREFETCH_DECIDE)
                   && !hold_full_nxt
                   && !rd_cmd
                   && (sync_cnt != SYNC_LAST);

    // Content of the next frame, in priority order sync > command > idle.
    always_comb begin
        next_word = IDLE_WORD;
        next_type = FT_IDLE;
        if (sync_due) begin
            next_word = SYNC_WORD;
            next_type = FT_SYNC;
        end else if (hold_full) begin
            next_word = hold_data;
            next_type = FT_CMD;
        end
    end

    // Command payload; loaded only on capture.
    // NOTE: this data register has no reset on purpose; hold_full alone says
    // whether its contents are meaningful, so clearing it would buy nothing.
    always_ff @(posedge clk160) begin
        if (capture) begin
            hold_data <= cmd_data;
        end
    end

    // Serializer FSM with registered outputs, hold flag and counters.
    always_ff @(posedge clk160) begin
        // NOTE: sequential state uses non-blocking '<=' only, so every flop
        // samples the values from before this edge regardless of line order.
        if (!rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= 4'd0;
            shift_reg    <= 16'd0;
            sync_cnt     <= 8'd0;
            hold_full    <= 1'b0;
            rd_cmd       <= 1'b0;
            frame_start  <= 1'b0;
            frame_type   <= FT_NONE;
            cmd_sent_cnt <= 16'd0;
            ovf_err      <= 1'b0;
        end else begin
            hold_full   <= hold_full_nxt;
            rd_cmd      <= prefetch;
            frame_start <= 1'b0;
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end

            if (load_frame) begin
                state       <= ST_RUN;
                bit_cnt     <= 4'd0;
                shift_reg   <= next_word;
                frame_start <= 1'b1;
                frame_type  <= next_type;
                if (sync_due) begin
                    sync_cnt <= 8'd0;
                end else begin
                    sync_cnt <= sync_cnt + 8'd1;
                end
                if (take_hold) begin
                    cmd_sent_cnt <= cmd_sent_cnt + 16'd1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (frame_end) begin
                            // Enable dropped: the frame has finished, go quiet.
                            state      <= ST_IDLE;
                            bit_cnt    <= 4'd0;
                            shift_reg  <= 16'd0;
                            frame_type <= FT_NONE;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            shift_reg <= {shift_reg[14:0], 1'b0};
                        end
                    end
                    default: begin
                        bit_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_serializer.sv
// Self-checking bench for cmd_serializer. A FIFO model answers rd_cmd with
// cmd_valid one cycle later; a monitor rebuilds frames from ser_out; a
// frame-level reference model predicts the frame sequence from the rules.
module tb_cmd_serializer;

    localparam int          SI     = 4;
    localparam logic [15:0] SYNC_W = 16'h817E;
    localparam logic [15:0] IDLE_W = 16'h6969;
    localparam logic [1:0]  T_NONE = 2'b00;
    localparam logic [1:0]  T_SYNC = 2'b01;
    localparam logic [1:0]  T_IDLE = 2'b10;
    localparam logic [1:0]  T_CMD  = 2'b11;

    logic        clk160 = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data = 16'd0;
    logic        rd_cmd;
    logic        ser_out;
    logic        frame_start;
    logic [1:0]  frame_type;
    logic [15:0] cmd_sent_cnt;
    logic        ovf_err;

    always #5 clk160 = ~clk160;

    cmd_serializer #(
        .SYNC_INTERVAL(SI),
        .SYNC_WORD    (SYNC_W),
        .IDLE_WORD    (IDLE_W)
    ) dut (
        .clk160      (clk160),
        .rst         (rst),
        .en          (en),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .rd_cmd      (rd_cmd),
        .ser_out     (ser_out),
        .frame_start (frame_start),
        .frame_type  (frame_type),
        .cmd_sent_cnt(cmd_sent_cnt),
        .ovf_err     (ovf_err)
    );

    typedef struct {
        logic [15:0] word;
        logic [1:0]  ftype;
        logic [15:0] cnt;
        int          start;
    } frame_t;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mon_f = -1;
    int          nbits = 16;
    int          cur_off = -1;
    frame_t      cur;
    frame_t      obs_q[$];
    frame_t      exp_q[$];
    logic [15:0] shw;
    logic [15:0] fifo_q[$];
    logic [15:0] pre_q[$];
    int          rd_cnt[64];
    int          rd_off[64];
    logic [15:0] val_data[$];
    int          val_cyc[$];
    logic        rd_prev = 1'b0;
    logic        inject_now = 1'b0;
    logic [15:0] inject_data = 16'd0;
    logic        plan_en = 1'b0;
    logic        plan_valid[64];
    logic [15:0] plan_word[64];

    // One clock cycle: FIFO response, then frame/read monitoring.
    task automatic tick();
        @(negedge clk160);
        cyc++;
        if (inject_now) begin
            cmd_valid  = 1'b1;
            cmd_data   = inject_data;
            inject_now = 1'b0;
        end else if (rd_prev === 1'b1 && fifo_q.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_data  = fifo_q.pop_front();
            val_data.push_back(cmd_data);
            val_cyc.push_back(cyc);
        end else begin
            cmd_valid = 1'b0;
            cmd_data  = 16'($urandom);
        end
        rd_prev = rd_cmd;
        if (frame_start === 1'b1) begin
            mon_f++;
            cur.ftype = frame_type;
            cur.cnt   = cmd_sent_cnt;
            cur.start = cyc;
            nbits     = 0;
            shw       = 16'd0;
            if (plan_en && mon_f < 64 && plan_valid[mon_f]) begin
                fifo_q.push_back(plan_word[mon_f]);
            end
        end
        if (mon_f >= 0) begin
            cur_off = cyc - cur.start;
        end
        if (mon_f >= 0 && nbits < 16) begin
            shw = {shw[14:0], ser_out};
            nbits++;
            if (nbits == 16) begin
                cur.word = shw;
                obs_q.push_back(cur);
            end
        end
        if (rd_cmd === 1'b1 && mon_f >= 0 && mon_f < 64) begin
            rd_cnt[mon_f]++;
            rd_off[mon_f] = cur_off;
        end
    endtask

    task automatic mon_clear();
        mon_f   = -1;
        nbits   = 16;
        cur_off = -1;
        obs_q.delete();
        val_data.delete();
        val_cyc.delete();
        for (int i = 0; i < 64; i++) begin
            rd_cnt[i] = 0;
            rd_off[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        inject_now = 1'b0;
        plan_en = 1'b0;
        fifo_q.delete();
        pre_q.delete();
        for (int i = 0; i < 64; i++) begin
            plan_valid[i] = 1'b0;
            plan_word[i]  = 16'd0;
        end
        repeat (3) tick();
        rst = 1'b1;
        mon_clear();
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (obs_q.size() < n && k < n * 16 + 64) begin
            tick();
            k++;
        end
        if (obs_q.size() < n) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s timeout: got %0d frames, want %0d", tag, obs_q.size(), n);
        end
    endtask

    task automatic wait_at(input int f, input int off, input string tag);
        int k;
        k = 0;
        while (!(mon_f == f && cur_off == off) && k < 300) begin
            tick();
            k++;
        end
        if (!(mon_f == f && cur_off == off)) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s timeout: frame %0d offset %0d never reached", tag, f, off);
        end
    endtask

    // Frame-level reference: sync at frame 0 and every SI frames after the
    // last sync; otherwise the oldest available FIFO word, else idle.
    // Words pushed during frame j can only be read for frame j+1.
    function automatic void build_model(input int nframes);
        logic [15:0] q[$];
        int          last_sync;
        logic [15:0] sent;
        frame_t      e;
        q = pre_q;
        exp_q.delete();
        last_sync = 0;
        sent = 16'd0;
        for (int j = 0; j < nframes; j++) begin
            if (j == 0 || j - last_sync == SI) begin
                e.word = SYNC_W;
                e.ftype = T_SYNC;
                last_sync = j;
            end else if (q.size() > 0) begin
                e.word = q.pop_front();
                e.ftype = T_CMD;
                sent++;
            end else begin
                e.word = IDLE_W;
                e.ftype = T_IDLE;
            end
            e.cnt = sent;
            e.start = 0;
            exp_q.push_back(e);
            if (plan_en && plan_valid[j]) begin
                q.push_back(plan_word[j]);
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();
        n_assert++;
        if ({ser_out, rd_cmd, frame_start, frame_type, ovf_err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ser=%b rd=%b fs=%b ft=%b ovf=%b, want all 0",
                     ser_out, rd_cmd, frame_start, frame_type, ovf_err);
        end
        n_assert++;
        if (cmd_sent_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0000", cmd_sent_cnt);
        end
        rst = 1'b1;
        repeat (4) tick();
        n_assert++;
        if ({ser_out, frame_start, frame_type} !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_quiet: got ser=%b fs=%b ft=%b want 0", ser_out, frame_start, frame_type);
        end
    endtask

    task automatic test_idle_stream();
        int ob;
        int ex;
        do_reset();
        build_model(6);
        en = 1'b1;
        tick();
        n_assert++;
        if (frame_start !== 1'b1 || ser_out !== SYNC_W[15]) begin
            n_fail++;
            $display("FAIL start_latency: got fs=%b ser=%b want fs=1 ser=%b", frame_start, ser_out, SYNC_W[15]);
        end
        wait_frames(6, "idle_stream");
        for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
            n_assert++;
            if ({obs_q[j].word, obs_q[j].ftype, obs_q[j].cnt} !== {exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt}) begin
                n_fail++;
                $display("FAIL idle_frame %0d: got %h/%b/%0d want %h/%b/%0d", j, obs_q[j].word,
                         obs_q[j].ftype, obs_q[j].cnt, exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt);
            end
        end
        for (int j = 0; j < 5; j++) begin
            ob = (rd_cnt[j] == 0) ? -1 : ((rd_cnt[j] == 1) ? rd_off[j] : 100 + rd_cnt[j]);
            ex = (exp_q[j + 1].ftype != T_SYNC) ? 12 : -1;
            n_assert++;
            if (ob != ex) begin
                n_fail++;
                $display("FAIL idle_rd frame %0d: got %0d want %0d", j, ob, ex);
            end
        end
    endtask

    task automatic test_preload();
        do_reset();
        pre_q.push_back(16'hA5C3);
        pre_q.push_back(16'h1234);
        fifo_q = pre_q;
        build_model(4);
        en = 1'b1;
        wait_frames(4, "preload");
        for (int j = 0; j < 4 && j < obs_q.size(); j++) begin
            n_assert++;
            if ({obs_q[j].word, obs_q[j].ftype, obs_q[j].cnt} !== {exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt}) begin
                n_fail++;
                $display("FAIL preload_frame %0d: got %h/%b/%0d want %h/%b/%0d", j, obs_q[j].word,
                         obs_q[j].ftype, obs_q[j].cnt, exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt);
            end
        end
        n_assert++;
        if (val_data.size() < 1 || obs_q.size() < 2) begin
            n_fail++;
            $display("FAIL preload_latency: no valid/frame recorded");
        end else if (val_data[0] !== 16'hA5C3 || obs_q[1].start - val_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL preload_latency: got data %h latency %0d want A5C3 latency 3",
                     val_data[0], obs_q[1].start - val_cyc[0]);
        end
        n_assert++;
        if (cmd_sent_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL preload_cnt: got %0d want 2", cmd_sent_cnt);
        end
    endtask

    task automatic test_sync_interval();
        int ob;
        int ex;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pre_q.push_back(16'($urandom));
        end
        fifo_q = pre_q;
        build_model(10);
        en = 1'b1;
        wait_frames(10, "sync_interval");
        for (int j = 0; j < 10 && j < obs_q.size(); j++) begin
            n_assert++;
            if ({obs_q[j].word, obs_q[j].ftype, obs_q[j].cnt} !== {exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt}) begin
                n_fail++;
                $display("FAIL sync_frame %0d: got %h/%b/%0d want %h/%b/%0d", j, obs_q[j].word,
                         obs_q[j].ftype, obs_q[j].cnt, exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt);
            end
        end
        for (int j = 0; j < 9; j++) begin
            ob = (rd_cnt[j] == 0) ? -1 : ((rd_cnt[j] == 1) ? rd_off[j] : 100 + rd_cnt[j]);
            ex = (exp_q[j + 1].ftype != T_SYNC) ? 12 : -1;
            n_assert++;
            if (ob != ex) begin
                n_fail++;
                $display("FAIL sync_rd frame %0d: got %0d want %0d", j, ob, ex);
            end
        end
        for (int j = 1; j < 10 && j < obs_q.size(); j++) begin
            n_assert++;
            if (obs_q[j].start - obs_q[j - 1].start != 16) begin
                n_fail++;
                $display("FAIL frame_period %0d: got %0d want 16", j, obs_q[j].start - obs_q[j - 1].start);
            end
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin
            pre_q.push_back(16'($urandom));
        end
        fifo_q = pre_q;
        plan_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            plan_valid[i] = ($urandom_range(99, 0) < 55);
            plan_word[i]  = 16'($urandom);
        end
        build_model(20);
        en = 1'b1;
        wait_frames(20, "random");
        for (int j = 0; j < 20 && j < obs_q.size(); j++) begin
            n_assert++;
            if ({obs_q[j].word, obs_q[j].ftype, obs_q[j].cnt} !== {exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt}) begin
                n_fail++;
                $display("FAIL random_frame %0d: got %h/%b/%0d want %h/%b/%0d", j, obs_q[j].word,
                         obs_q[j].ftype, obs_q[j].cnt, exp_q[j].word, exp_q[j].ftype, exp_q[j].cnt);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w1;
        logic [15:0] w2;
        do_reset();
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        fifo_q.push_back(w1);
        fifo_q.push_back(w2);
        en = 1'b1;
        wait_at(0, 13, "ovf_align");
        n_assert++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_before: got %b want 0", ovf_err);
        end
        inject_data = ~w1;
        inject_now  = 1'b1;
        tick();
        tick();
        n_assert++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b want 1", ovf_err);
        end
        wait_frames(4, "overflow");
        n_assert++;
        if (obs_q.size() < 4) begin
            n_fail++;
            $display("FAIL ovf_frames: got %0d frames want 4", obs_q.size());
        end else if ({obs_q[1].word, obs_q[1].ftype, obs_q[2].word, obs_q[2].ftype, obs_q[3].ftype}
                     !== {w1, T_CMD, w2, T_CMD, T_IDLE}) begin
            n_fail++;
            $display("FAIL ovf_frames: got %h/%b %h/%b %b want %h/11 %h/11 10", obs_q[1].word,
                     obs_q[1].ftype, obs_q[2].word, obs_q[2].ftype, obs_q[3].ftype, w1, w2);
        end
        repeat (20) tick();
        n_assert++;
        if (ovf_err !== 1'b1 || cmd_sent_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want ovf=1 cnt=2", ovf_err, cmd_sent_cnt);
        end
    endtask

    task automatic test_en_drop();
        logic [15:0] w[3];
        logic        bad;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            fifo_q.push_back(w[i]);
        end
        en = 1'b1;
        wait_at(1, 5, "en_drop_align");
        en = 1'b0;
        wait_frames(2, "en_drop_finish");
        n_assert++;
        if (obs_q.size() < 2 || obs_q[1].word !== w[0] || obs_q[1].ftype !== T_CMD) begin
            n_fail++;
            $display("FAIL en_drop_frame: got %h want %h", (obs_q.size() > 1) ? obs_q[1].word : 16'hxxxx, w[0]);
        end
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (ser_out !== 1'b0 || frame_start !== 1'b0 || frame_type !== T_NONE || rd_cmd !== 1'b0) begin
                bad = 1'b1;
            end
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL en_drop_idle: got activity while disabled, want quiet outputs");
        end
        mon_clear();
        en = 1'b1;
        wait_frames(3, "re_enable");
        n_assert++;
        if (obs_q.size() < 3) begin
            n_fail++;
            $display("FAIL re_enable: got %0d frames want 3", obs_q.size());
        end else if ({obs_q[0].word, obs_q[1].word, obs_q[1].cnt, obs_q[2].word, obs_q[2].cnt}
                     !== {SYNC_W, w[1], 16'd2, w[2], 16'd3}) begin
            n_fail++;
            $display("FAIL re_enable: got %h %h/%0d %h/%0d want %h %h/2 %h/3", obs_q[0].word,
                     obs_q[1].word, obs_q[1].cnt, obs_q[2].word, obs_q[2].cnt, SYNC_W, w[1], w[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        fifo_q.push_back(16'($urandom));
        en = 1'b1;
        wait_at(1, 8, "rst_align");
        n_assert++;
        if (frame_type !== T_CMD) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got type %b want 11", frame_type);
        end
        rst = 1'b0;
        tick();
        n_assert++;
        if ({ser_out, rd_cmd, frame_start, frame_type, ovf_err, cmd_sent_cnt} !== 22'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got ser=%b rd=%b fs=%b ft=%b ovf=%b cnt=%0d want all 0",
                     ser_out, rd_cmd, frame_start, frame_type, ovf_err, cmd_sent_cnt);
        end
        rst = 1'b1;
        en  = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (ser_out !== 1'b0 || frame_start !== 1'b0) begin
                bad = 1'b1;
            end
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_no_resume: got frame activity after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_idle_stream();
        test_preload();
        test_sync_interval();
        test_random_traffic();
        test_overflow();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
